pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 6-stage pipeline: pc, if, id, ex, mem, wb.
- Merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register.
- Sequences exception and ERET flushes, and supplies the redirect PC.
- Runs a bus-wait watchdog and a stall-cycle performance counter.
- Sits beside the pipeline registers. Its stall and flush outputs drive them directly; its new_pc output drives pc_reg.

---
 rtl/pipe_stall_ctrl_if.sv | 30 +++
 rtl/pipe_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush sequencer bundle: per-stage stall requests and exception
// reports flow from the pipeline (master) into the sequencer (slave);
// stall vector, flush, redirect PC and the watchdog/perf results flow back.
interface pipe_stall_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        except_valid;
    logic        except_eret;
    logic [31:0] epc;
    logic        perf_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bus_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output except_valid, except_eret, epc, perf_clr,
        input  stall, flush, new_pc, bus_timeout, stall_cycles
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  except_valid, except_eret, epc, perf_clr,
        output stall, flush, new_pc, bus_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the pc/if/id/ex/mem/wb pipeline.
// Merges stall requests into a per-stage stall vector, takes exceptions and
// ERETs (deferring them while the data bus is busy), runs a bus-wait watchdog
// and counts stalled cycles. rst is asynchronous and active-low.
module pipe_stall_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   bus
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        pend;
    logic        pend_eret;
    logic [31:0] pend_epc;
    logic [15:0] wd_cnt;
    logic [31:0] perf_cnt;

    logic        bus_req;
    logic        wd_fire;
    logic        take;
    logic        take_eret;
    logic [31:0] take_epc;
    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;
    logic        timeout_c;

    // Highest stalled stage freezes itself and everything upstream of it.
    function automatic logic [5:0] encode(input logic mem, input logic ex,
                                          input logic id, input logic ifs);
        if (mem)      return 6'b011111;
        else if (ex)  return 6'b001111;
        else if (id)  return 6'b000111;
        else if (ifs) return 6'b000011;
        else          return 6'b000000;
    endfunction

    assign bus_req   = bus.stallreq_if | bus.stallreq_mem;
    assign wd_fire   = bus_req && (wd_cnt == WD_LAST);
    assign take      = (state == RUN) && (bus.except_valid || pend) && !bus.stallreq_mem;
    assign take_eret = pend ? pend_eret : bus.except_eret;
    assign take_epc  = pend ? pend_epc  : bus.epc;

    // Next state and per-cycle outputs; watchdog beats a normal take, and
    // DRAIN ignores the stale id/ex requests left over from the flushed stages.
    always_comb begin
        stall_c   = 6'b000000;
        flush_c   = 1'b0;
        new_pc_c  = 32'h0;
        timeout_c = 1'b0;
        state_nxt = RUN;
        if (wd_fire) begin
            timeout_c = 1'b1;
            flush_c   = 1'b1;
            new_pc_c  = EXC_VECTOR;
            state_nxt = DRAIN;
        end else if (state == RUN) begin
            if (take) begin
                flush_c   = 1'b1;
                new_pc_c  = take_eret ? take_epc : EXC_VECTOR;
                state_nxt = DRAIN;
            end else begin
                stall_c = encode(bus.stallreq_mem, bus.stallreq_ex,
                                 bus.stallreq_id, bus.stallreq_if);
            end
        end else begin
            stall_c = encode(bus.stallreq_mem, 1'b0, 1'b0, bus.stallreq_if);
        end
    end

    // Outputs are forced quiet while reset is held.
    assign bus.stall        = rst ? stall_c   : 6'b000000;
    assign bus.flush        = rst ? flush_c   : 1'b0;
    assign bus.new_pc       = rst ? new_pc_c  : 32'h0;
    assign bus.bus_timeout  = rst ? timeout_c : 1'b0;
    assign bus.stall_cycles = perf_cnt;

    // Sequencer state: RUN normally, one DRAIN cycle after every flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    // Oldest exception seen while mem stalls is held until the bus frees up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend      <= 1'b0;
            pend_eret <= 1'b0;
            pend_epc  <= 32'h0;
        end else if (wd_fire || take) begin
            pend <= 1'b0;
        end else if ((state == RUN) && bus.except_valid && bus.stallreq_mem && !pend) begin
            pend      <= 1'b1;
            pend_eret <= bus.except_eret;
            pend_epc  <= bus.epc;
        end
    end

    // Watchdog counts consecutive bus-wait cycles and restarts after firing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         wd_cnt <= 16'h0;
        else if (wd_fire) wd_cnt <= 16'h0;
        else if (bus_req) wd_cnt <= wd_cnt + 16'd1;
        else              wd_cnt <= 16'h0;
    end

    // Stalled-cycle performance counter; a clear wins over the increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      perf_cnt <= 32'h0;
        else if (bus.perf_clr)         perf_cnt <= 32'h0;
        else if (stall_c != 6'b000000) perf_cnt <= perf_cnt + 32'd1;
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by
// randomized traffic compared against a behavioural model of the sequencer.
module tb_pipe_stall_ctrl;

    localparam logic [31:0] VEC = 32'h0000_0020;
    localparam int          TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(
        .EXC_VECTOR (VEC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_drain;
    bit          h_valid;
    bit          h_eret;
    logic [31:0] h_epc;
    int          m_wait;
    logic [31:0] m_count;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_tmo;
    bit          e_fire;
    bit          e_take;

    task automatic drive(input logic sif, input logic sid, input logic sex, input logic smem,
                         input logic ev, input logic er, input logic [31:0] pc, input logic clr);
        bus.stallreq_if  = sif;
        bus.stallreq_id  = sid;
        bus.stallreq_ex  = sex;
        bus.stallreq_mem = smem;
        bus.except_valid = ev;
        bus.except_eret  = er;
        bus.epc          = pc;
        bus.perf_clr     = clr;
    endtask

    task automatic model_reset();
        m_drain = 0; h_valid = 0; h_eret = 0; h_epc = '0; m_wait = 0; m_count = '0;
    endtask

    task automatic model_eval();
        bit busw;
        int top;
        busw   = bus.stallreq_if | bus.stallreq_mem;
        e_fire = busw && (m_wait + 1 == TMO);
        e_take = !e_fire && !m_drain && (bus.except_valid || h_valid) && !bus.stallreq_mem;
        top = 0;
        if (bus.stallreq_mem)                 top = 4;
        else if (!m_drain && bus.stallreq_ex) top = 3;
        else if (!m_drain && bus.stallreq_id) top = 2;
        else if (bus.stallreq_if)             top = 1;
        e_stall = (e_fire || e_take || top == 0) ? 6'd0 : 6'((1 << (top + 1)) - 1);
        e_flush = e_fire || e_take;
        e_tmo   = e_fire;
        if (e_fire)      e_pc = VEC;
        else if (e_take) e_pc = (h_valid ? h_eret : bus.except_eret) ? (h_valid ? h_epc : bus.epc) : VEC;
        else             e_pc = '0;
    endtask

    task automatic model_step();
        bit busw;
        busw    = bus.stallreq_if | bus.stallreq_mem;
        m_count = bus.perf_clr ? 32'h0 : m_count + ((e_stall != 0) ? 32'd1 : 32'd0);
        m_wait  = e_fire ? 0 : (busw ? m_wait + 1 : 0);
        if (e_fire || e_take) h_valid = 0;
        else if (!m_drain && bus.except_valid && bus.stallreq_mem && !h_valid) begin
            h_valid = 1; h_eret = bus.except_eret; h_epc = bus.epc;
        end
        m_drain = e_fire || e_take;
    endtask

    task automatic test_reset();
        drive(0, 0, 1, 0, 0, 0, 32'h0, 0);
        @(negedge clk); #1;
        n_checks++;
        if (bus.stall !== 6'b001111) begin n_fail++; $display("[TB] FAIL reset_pre stall got %b want 001111", bus.stall); end
        @(negedge clk); #2;
        rst = 1'b0; #1;
        n_checks++;
        if (bus.stall !== 6'b000000) begin n_fail++; $display("[TB] FAIL reset_stall got %b want 000000", bus.stall); end
        n_checks++;
        if (bus.stall_cycles !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_cycles got %h want 0", bus.stall_cycles); end
        n_checks++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0 || bus.bus_timeout !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_outs got flush=%b pc=%h tmo=%b want 0", bus.flush, bus.new_pc, bus.bus_timeout);
        end
        @(negedge clk);
        rst = 1'b1; #1;
        n_checks++;
        if (bus.stall !== 6'b001111) begin n_fail++; $display("[TB] FAIL reset_release stall got %b want 001111", bus.stall); end
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
    endtask

    task automatic test_priority();
        drive(1, 1, 0, 1, 0, 0, 32'h0, 0); #1;
        n_checks++;
        if (bus.stall !== 6'b011111) begin n_fail++; $display("[TB] FAIL prio_mem got %b want 011111", bus.stall); end
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0, 32'h0, 0); #1;
        n_checks++;
        if (bus.stall !== 6'b000111) begin n_fail++; $display("[TB] FAIL prio_id got %b want 000111", bus.stall); end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0); #1;
        n_checks++;
        if (bus.stall !== 6'b000011) begin n_fail++; $display("[TB] FAIL prio_if got %b want 000011", bus.stall); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
    endtask

    task automatic test_exception();
        drive(0, 0, 0, 0, 1, 0, 32'h1234_5678, 0); #1;
        n_checks++;
        if (bus.flush !== 1'b1 || bus.new_pc !== VEC || bus.stall !== 6'b0) begin
            n_fail++; $display("[TB] FAIL exc_take got flush=%b pc=%h stall=%b want 1/%h/000000", bus.flush, bus.new_pc, bus.stall, VEC);
        end
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 0, 32'h0, 0); #1;
        n_checks++;
        if (bus.stall !== 6'b0 || bus.flush !== 1'b0) begin
            n_fail++; $display("[TB] FAIL exc_drain got stall=%b flush=%b want 000000/0", bus.stall, bus.flush);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.stall !== 6'b001111) begin n_fail++; $display("[TB] FAIL exc_resume got %b want 001111", bus.stall); end
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
    endtask

    task automatic test_eret_deferred();
        for (int c = 1; c <= 3; c++) begin
            if (c == 1)      drive(0, 0, 0, 1, 1, 1, 32'h8000_1234, 0);
            else if (c == 2) drive(0, 0, 0, 1, 1, 0, 32'hDEAD_BEEF, 0);
            else             drive(0, 0, 0, 1, 0, 0, 32'h0, 0);
            #1;
            n_checks++;
            if (bus.stall !== 6'b011111 || bus.flush !== 1'b0) begin
                n_fail++; $display("[TB] FAIL eret_wait c%0d got stall=%b flush=%b want 011111/0", c, bus.stall, bus.flush);
            end
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0); #1;
        n_checks++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'h8000_1234) begin
            n_fail++; $display("[TB] FAIL eret_take got flush=%b pc=%h want 1/80001234", bus.flush, bus.new_pc);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.flush !== 1'b0) begin n_fail++; $display("[TB] FAIL eret_once got flush=%b want 0", bus.flush); end
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        drive(0, 0, 0, 1, 0, 0, 32'h0, 0);
        for (int c = 1; c <= 8; c++) begin
            bit fire;
            fire = (c == 4) || (c == 8);
            #1;
            n_checks++;
            if (bus.bus_timeout !== fire || bus.flush !== fire ||
                bus.stall !== (fire ? 6'b000000 : 6'b011111) || bus.new_pc !== (fire ? VEC : 32'h0)) begin
                n_fail++;
                $display("[TB] FAIL wd_hold c%0d got tmo=%b flush=%b stall=%b pc=%h want tmo=%b", c,
                         bus.bus_timeout, bus.flush, bus.stall, bus.new_pc, fire);
            end
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            if (c <= 3) drive(0, 0, 0, 1, 0, 0, 32'h0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
            #1;
            n_checks++;
            if (bus.bus_timeout !== 1'b0 || bus.flush !== 1'b0) begin
                n_fail++; $display("[TB] FAIL wd_short c%0d got tmo=%b flush=%b want 0/0", c, bus.bus_timeout, bus.flush);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_counter();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFFF; want[1] = 32'h0; want[2] = 32'h1;
        #1;
        dut.perf_cnt = 32'hFFFF_FFFE;
        drive(0, 0, 1, 0, 0, 0, 32'h0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (bus.stall_cycles !== want[c]) begin
                n_fail++; $display("[TB] FAIL cnt_wrap c%0d got %h want %h", c, bus.stall_cycles, want[c]);
            end
        end
        drive(0, 0, 1, 0, 0, 0, 32'h0, 1);
        @(negedge clk); #1;
        n_checks++;
        if (bus.stall_cycles !== 32'h0) begin n_fail++; $display("[TB] FAIL cnt_clr got %h want 0", bus.stall_cycles); end
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
    endtask

    task automatic test_random();
        #1; rst = 1'b0; #1; rst = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            drive($urandom % 4 == 0, $urandom % 5 == 0, $urandom % 5 == 0, $urandom % 3 == 0,
                  !m_drain && ($urandom % 6 == 0), $urandom % 2 == 1, $urandom, $urandom % 16 == 0);
            #1;
            model_eval();
            n_checks++;
            if (bus.stall !== e_stall || bus.flush !== e_flush || bus.new_pc !== e_pc ||
                bus.bus_timeout !== e_tmo || bus.stall_cycles !== m_count) begin
                n_fail++;
                $display("[TB] FAIL rand i%0d got stall=%b flush=%b pc=%h tmo=%b cnt=%h want stall=%b flush=%b pc=%h tmo=%b cnt=%h",
                         i, bus.stall, bus.flush, bus.new_pc, bus.bus_timeout, bus.stall_cycles,
                         e_stall, e_flush, e_pc, e_tmo, m_count);
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_priority();
        test_exception();
        test_eret_deferred();
        test_watchdog();
        test_counter();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
